// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Single-port access sequencer that sits in front of the unified
// instruction/data memory of the multicycle processor. It arbitrates between
// instruction fetches and load/stores coming from the control unit. It checks
// data alignment and builds the byte enables and sign flag. It then drives
// registered address/data/strobes to the memory for exactly one cycle. The
// combinational read data is captured and handed back with a one-cycle done
// pulse.
//
// Transaction timing: grant in cycle N, memory strobes in N+1, done in N+2,
// and the next grant in N+3 at the earliest. A misaligned access or a
// reserved size skips the memory and reports done+err in N+1.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_req_i          fetch request, held by the requester until granted
//   if_addr_i         fetch byte address (low two bits ignored)
//   if_gnt_o          fetch accepted this cycle
//   if_done_o         one-cycle pulse, if_rdata_o valid
//   if_rdata_o        fetched instruction word
//   d_req_i           load/store request, held until granted
//   d_we_i            1 = store, 0 = load
//   d_size_i          00 byte, 01 half, 10 word, 11 reserved
//   d_sign_i          sign-extend loads (lb/lh)
//   d_addr_i          data byte address
//   d_wdata_i         right-justified store data
//   d_gnt_o           data request accepted this cycle
//   d_done_o          one-cycle completion pulse for loads and stores
//   d_err_o           with d_done_o: misaligned/reserved, memory untouched
//   d_rdata_o         load result (already extended by the memory)
//   mem_addr_o        byte address to memory
//   mem_wdata_o       unshifted store data to memory
//   mem_write_o       memory write strobe
//   mem_read_o        memory read enable
//   mem_be_o          byte enables
//   mem_sign_o        sign-extension select for the memory
//   mem_rdata_i       combinational memory read data
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_done_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [1:0]        d_size_i,
   input  logic              d_sign_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_done_o,
   output logic              d_err_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_write_o,
   output logic              mem_read_o,
   output logic [3:0]        mem_be_o,
   output logic              mem_sign_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              owner_d;
   logic              lat_we;
   logic              d_misaligned;
   logic [3:0]        d_be;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        be_q;
   logic              sign_q;
   logic              read_q;
   logic              write_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_addr_unused;

   assign if_addr_unused = ^if_addr_i[1:0];

   // Decode the data request: byte enables follow the access size and the
   // low address bits, and anything that does not sit on its natural boundary
   // (or uses the reserved size) is flagged so it never reaches the memory.
   always_comb begin
      d_misaligned = 1'b0;
      d_be         = 4'b0000;
      case (d_size_i)
         2'b00: begin
            d_be = 4'b0001 << d_addr_i[1:0];
         end
         2'b01: begin
            d_misaligned = d_addr_i[0];
            d_be         = d_addr_i[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            d_misaligned = |d_addr_i[1:0];
            d_be         = 4'b1111;
         end
         default: begin
            d_misaligned = 1'b1;
         end
      endcase
   end

   // Grants exist only while idle and never while reset is asserted. Data
   // accesses win over fetches; a losing fetch stays requested and is picked
   // up in the next idle cycle.
   always_comb begin
      d_gnt_o  = (state == IDLE) & ~rst & d_req_i;
      if_gnt_o = (state == IDLE) & ~rst & if_req_i & ~d_req_i;
   end

   // State register. Reset always returns to IDLE, which also kills any
   // done pulse that would otherwise have appeared after RESP/ERR.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: a granted access spends one cycle on the memory bus
   // (ISSUE) and one returning the result (RESP); a rejected data access
   // reports its error in a single ERR cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (d_gnt_o) begin
               state_nxt = d_misaligned ? ERR : ISSUE;
            end else if (if_gnt_o) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch and memory-side registers. On a grant the bus fields are
   // loaded so the strobes appear, already stable, in the ISSUE cycle. At the
   // end of ISSUE the strobes are dropped and, for reads, the combinational
   // memory data is captured into the owner's result register. The address,
   // store data and sign flag are left holding their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_d    <= 1'b0;
         lat_we     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= 4'b0000;
         sign_q     <= 1'b0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_gnt_o) begin
                  owner_d <= 1'b1;
                  lat_we  <= d_we_i;
                  if (!d_misaligned) begin
                     addr_q  <= d_addr_i;
                     wdata_q <= d_wdata_i;
                     be_q    <= d_be;
                     sign_q  <= d_sign_i;
                     read_q  <= ~d_we_i;
                     write_q <= d_we_i;
                  end
               end else if (if_gnt_o) begin
                  owner_d <= 1'b0;
                  lat_we  <= 1'b0;
                  addr_q  <= {if_addr_i[ADDR_W-1:2], 2'b00};
                  wdata_q <= '0;
                  be_q    <= 4'b1111;
                  sign_q  <= 1'b0;
                  read_q  <= 1'b1;
                  write_q <= 1'b0;
               end
            end
            ISSUE: begin
               read_q  <= 1'b0;
               write_q <= 1'b0;
               be_q    <= 4'b0000;
               if (!lat_we) begin
                  if (owner_d) begin
                     d_rdata_q <= mem_rdata_i;
                  end else begin
                     if_rdata_q <= mem_rdata_i;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Completion pulses come straight from the state: RESP pulses the owner's
   // done, ERR is always a data completion with the error flag.
   always_comb begin
      d_done_o  = ((state == RESP) & owner_d) | (state == ERR);
      d_err_o   = (state == ERR);
      if_done_o = (state == RESP) & ~owner_d;
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = be_q;
   assign mem_sign_o  = sign_q;
   assign mem_read_o  = read_q;
   assign mem_write_o = write_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Scoreboard bench for mem_access_unit. The stimulus process issues directed
// requests with hand-computed results and pushes the expected memory access
// and the expected completion into queues. Two monitor processes pop and
// compare whenever the DUT shows a memory strobe or a done pulse. A small
// word memory model supplies read data (lane-selected and extended) and
// applies byte-enabled stores.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = '0;
   logic        if_gnt_o;
   logic        if_done_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [1:0]  d_size_i = 2'b00;
   logic        d_sign_i = 1'b0;
   logic [31:0] d_addr_i = '0;
   logic [31:0] d_wdata_i = '0;
   logic        d_gnt_o;
   logic        d_done_o;
   logic        d_err_o;
   logic [31:0] d_rdata_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_write_o;
   logic        mem_read_o;
   logic [3:0]  mem_be_o;
   logic        mem_sign_o;
   logic [31:0] mem_rdata_i;

   typedef struct {
      bit          is_data;
      bit          err;
      logic [31:0] rdata;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          sign;
      bit          wr;
      int          cyc;
   } acc_t;

   resp_t       resp_q[$];
   acc_t        acc_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [31:0] last_d = '0;
   logic [31:0] last_if = '0;
   logic [31:0] mem [0:4095];
   logic [11:0] widx;
   logic [31:0] raw;
   logic [31:0] shifted;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
      .d_sign_i(d_sign_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_gnt_o(d_gnt_o), .d_done_o(d_done_o), .d_err_o(d_err_o),
      .d_rdata_o(d_rdata_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
      .mem_be_o(mem_be_o), .mem_sign_o(mem_sign_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   // Cycle counter used to check grant-to-strobe and grant-to-done latency.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory read path: pick the addressed lane(s) and extend them the way
   // the real memory does for byte and halfword loads.
   assign widx = mem_addr_o[13:2];
   always_comb begin
      raw         = mem[widx];
      shifted     = raw >> {mem_addr_o[1:0], 3'b000};
      mem_rdata_i = raw;
      case (mem_be_o)
         4'b0001, 4'b0010, 4'b0100, 4'b1000:
            mem_rdata_i = mem_sign_o ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'h0, shifted[7:0]};
         4'b0011, 4'b1100:
            mem_rdata_i = mem_sign_o ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'h0, shifted[15:0]};
         default: mem_rdata_i = raw;
      endcase
   end

   // Memory contents and write path. Writes are not gated by reset, so a
   // store strobed in the cycle rst rises still lands.
   initial begin
      logic [31:0] wsh;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[0]       = 32'h80011234;
      mem[1]       = 32'h11223344;
      mem[2]       = 32'h00005678;
      mem[12'hC00] = 32'h8C010004;
      mem[12'hC01] = 32'h00000013;
      forever begin
         @(posedge clk);
         if (mem_write_o) begin
            wsh = mem_wdata_o << {mem_addr_o[1:0], 3'b000};
            for (int b = 0; b < 4; b++) begin
               if (mem_be_o[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, " strobes/be/sign"},
                  {26'h0, mem_read_o, mem_write_o, mem_be_o[3:1] | {2'b0, mem_sign_o}},
                  32'h0);
      checkOutput({tag, " mem_be_o"}, {28'h0, mem_be_o}, 32'h0);
      checkOutput({tag, " mem_addr_o"}, mem_addr_o, 32'h0);
      checkOutput({tag, " mem_wdata_o"}, mem_wdata_o, 32'h0);
      checkOutput({tag, " done/err"}, {29'h0, d_done_o, d_err_o, if_done_o}, 32'h0);
      checkOutput({tag, " if_rdata_o"}, if_rdata_o, 32'h0);
      checkOutput({tag, " d_rdata_o"}, d_rdata_o, 32'h0);
   endtask

   // Wait (bounded) for the grant of the requested kind; sampled #1 after
   // the negedge where the inputs were driven.
   task automatic waitGrant(input bit want_data, output bit got);
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (want_data ? d_gnt_o : if_gnt_o) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("[TB] FAIL grant timeout: got none, expected %s grant",
                  want_data ? "data" : "fetch");
      end
   endtask

   // Push what the memory should see and what the requester should get back
   // for a request granted in cycle g.
   task automatic pushExpect(input bit is_data, input bit we, input bit sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input bit exp_err, input logic [3:0] exp_be,
                             input logic [31:0] exp_rdata, input bit exp_done,
                             input int g);
      acc_t  a;
      resp_t r;
      if (exp_err) begin
         r = '{is_data: 1'b1, err: 1'b1, rdata: last_d, cyc: g + 1};
         resp_q.push_back(r);
         return;
      end
      a = '{addr: addr, wdata: wdata, be: exp_be, sign: sign, wr: we, cyc: g + 1};
      acc_q.push_back(a);
      if (is_data && !we) last_d = exp_rdata;
      if (!is_data) last_if = exp_rdata;
      r = '{is_data: is_data, err: 1'b0, rdata: is_data ? last_d : last_if, cyc: g + 2};
      if (exp_done) resp_q.push_back(r);
   endtask

   task automatic applyStimulus(input bit is_data, input bit we,
                                input logic [1:0] size, input bit sign,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit exp_err, input logic [3:0] exp_be,
                                input logic [31:0] exp_rdata, input bit exp_done);
      bit got;
      @(negedge clk);
      if (is_data) begin
         d_we_i    = we;
         d_size_i  = size;
         d_sign_i  = sign;
         d_addr_i  = addr;
         d_wdata_i = wdata;
         d_req_i   = 1'b1;
      end else begin
         if_addr_i = addr;
         if_req_i  = 1'b1;
      end
      #1;
      waitGrant(is_data, got);
      if (got) begin
         pushExpect(is_data, we, is_data ? sign : 1'b0,
                    is_data ? addr : {addr[31:2], 2'b00}, wdata,
                    exp_err, exp_be, exp_rdata, exp_done, cyc);
         @(posedge clk);
         #1;
      end
      d_req_i  = 1'b0;
      if_req_i = 1'b0;
   endtask

   // Completion monitor: every done pulse must match the oldest expectation.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (d_done_o || if_done_o) begin
            if (resp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected done: got d_done=%b if_done=%b, expected none",
                        d_done_o, if_done_o);
            end else begin
               e = resp_q.pop_front();
               checkOutput("done owner", {30'h0, d_done_o, if_done_o},
                           {30'h0, e.is_data, ~e.is_data});
               checkOutput("d_err_o", {31'h0, d_err_o}, {31'h0, e.err});
               checkOutput("done latency", cyc, e.cyc);
               checkOutput(e.is_data ? "d_rdata_o" : "if_rdata_o",
                           e.is_data ? d_rdata_o : if_rdata_o, e.rdata);
            end
         end
      end
   end

   // Memory-side monitor: each strobe cycle must match the oldest expected
   // access, and strobes never last more than one cycle.
   initial begin
      acc_t a;
      bit   prev = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_read_o || mem_write_o) begin
            checkOutput("strobe width", {31'h0, prev}, 32'h0);
            if (acc_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected access: got rd=%b wr=%b addr=%h, expected none",
                        mem_read_o, mem_write_o, mem_addr_o);
            end else begin
               a = acc_q.pop_front();
               checkOutput("mem_addr_o", mem_addr_o, a.addr);
               checkOutput("mem_be_o", {28'h0, mem_be_o}, {28'h0, a.be});
               checkOutput("mem_sign_o", {31'h0, mem_sign_o}, {31'h0, a.sign});
               checkOutput("mem rd/wr", {30'h0, mem_write_o, mem_read_o},
                           {30'h0, a.wr, ~a.wr});
               checkOutput("strobe latency", cyc, a.cyc);
               if (a.wr) checkOutput("mem_wdata_o", mem_wdata_o, a.wdata);
            end
         end
         prev = mem_read_o | mem_write_o;
      end
   end

   initial begin
      bit got;
      int g0;

      // Reset state, including grant suppression while rst is high.
      repeat (3) @(negedge clk);
      checkIdleZero("reset");
      d_req_i = 1'b1;
      #1;
      checkOutput("d_gnt_o under rst", {31'h0, d_gnt_o}, 32'h0);
      d_req_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors: kind, we, size, sign, addr, wdata, err, be, rdata.
      applyStimulus(0, 0, 2'b10, 0, 32'h3000, 32'h0,        0, 4'b1111, 32'h8C010004, 1);
      applyStimulus(1, 1, 2'b00, 0, 32'h6,    32'h000000AB, 0, 4'b0100, 32'h0,        1);
      applyStimulus(1, 0, 2'b01, 1, 32'h2,    32'h0,        0, 4'b1100, 32'hFFFF8001, 1);
      applyStimulus(1, 0, 2'b10, 0, 32'h5,    32'h0,        1, 4'b0000, 32'h0,        1);
      applyStimulus(1, 0, 2'b11, 0, 32'h8,    32'h0,        1, 4'b0000, 32'h0,        1);
      applyStimulus(1, 0, 2'b00, 0, 32'h7,    32'h0,        0, 4'b1000, 32'h00000011, 1);
      applyStimulus(1, 0, 2'b00, 1, 32'h6,    32'h0,        0, 4'b0100, 32'hFFFFFFAB, 1);
      applyStimulus(1, 1, 2'b01, 0, 32'hA,    32'h0000BEEF, 0, 4'b1100, 32'h0,        1);
      applyStimulus(1, 1, 2'b01, 0, 32'h3,    32'h0000CAFE, 1, 4'b0000, 32'h0,        1);
      applyStimulus(1, 0, 2'b01, 0, 32'h0,    32'h0,        0, 4'b0011, 32'h00001234, 1);

      // Simultaneous fetch and load: data first, fetch three cycles later.
      @(negedge clk);
      d_we_i    = 1'b0;
      d_size_i  = 2'b10;
      d_sign_i  = 1'b0;
      d_addr_i  = 32'h8;
      d_req_i   = 1'b1;
      if_addr_i = 32'h3006;
      if_req_i  = 1'b1;
      #1;
      waitGrant(1'b1, got);
      checkOutput("arb if_gnt_o", {31'h0, if_gnt_o}, 32'h0);
      g0 = cyc;
      if (got) pushExpect(1, 0, 0, 32'h8, 32'h0, 0, 4'b1111, 32'hBEEF5678, 1, g0);
      @(posedge clk);
      #1;
      d_req_i = 1'b0;
      waitGrant(1'b0, got);
      checkOutput("fetch grant cycle", cyc, g0 + 3);
      if (got) pushExpect(0, 0, 0, 32'h3004, 32'h0, 0, 4'b1111, 32'h00000013, 1, cyc);
      @(posedge clk);
      #1;
      if_req_i = 1'b0;

      // Reset pulsed during the ISSUE cycle of a word store: the write lands,
      // no done follows, everything reads zero afterwards.
      applyStimulus(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkIdleZero("mid-op reset");
      checkOutput("store under reset", mem[4], 32'hDEADBEEF);
      last_d  = '0;
      last_if = '0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1, 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 1);
      applyStimulus(0, 0, 2'b10, 0, 32'h12, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 1);

      // Drain both scoreboards with a bounded wait.
      for (int k = 0; k < 10; k++) begin
         if (resp_q.size() == 0 && acc_q.size() == 0) break;
         @(negedge clk);
      end
      if (resp_q.size() != 0 || acc_q.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL scoreboard drain: got %0d responses and %0d accesses pending, expected 0",
                  resp_q.size(), acc_q.size());
      end
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
